// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
// Holds the scan FSM encoding and the row priority helper.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HOLD,
        REL_DEB
    } state_e;

    // Index of the lowest active-low row; only meaningful when one is low.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] row);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick.
// Tick fires on the last count so the first one lands SCAN_DIV cycles after reset.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the counter at the end of each scan period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) cnt_d = '0;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_matrix_encoder.sv
// 4x4 keypad scanner with press/release debounce.
// Replaces a 74C922-style encoder: latched code on {D,C,B,A}, E while held.
module keypad_matrix_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_ROWS-1:0] ROW,
    output logic [NUM_COLS-1:0] COL,
    output logic                A,
    output logic                B,
    output logic                C,
    output logic                D,
    output logic                E
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic                tick;
    logic [NUM_ROWS-1:0] sync1_q;
    logic [NUM_ROWS-1:0] sync2_q;
    state_e              state_q;
    logic [1:0]          col_q;
    logic [1:0]          cand_row_q;
    logic [1:0]          cand_col_q;
    logic [DW-1:0]       deb_cnt_q;
    logic [CODE_W-1:0]   code_q;
    logic                e_q;
    logic                any_low;
    logic                row_low;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk_i (CLK),
        .rst_i (RESET),
        .tick_o(tick)
    );

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= ROW;
            sync2_q <= sync1_q;
        end
    end

    assign any_low = ~&sync2_q;
    assign row_low = ~sync2_q[cand_row_q];

    // Scan/debounce FSM; all decisions happen on tick cycles only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= SCAN;
            col_q      <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            deb_cnt_q  <= '0;
            code_q     <= '0;
            e_q        <= 1'b0;
        end else if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cand_row_q <= lowest_low(sync2_q);
                        cand_col_q <= col_q;
                        deb_cnt_q  <= '0;
                        state_q    <= PRESS_DEB;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                PRESS_DEB: begin
                    if (row_low) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            code_q  <= {cand_row_q, cand_col_q};
                            e_q     <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        col_q   <= col_q + 1'b1;
                        state_q <= SCAN;
                    end
                end
                HOLD: begin
                    if (!row_low) begin
                        deb_cnt_q <= '0;
                        state_q   <= REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (!row_low) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            e_q     <= 1'b0;
                            col_q   <= col_q + 1'b1;
                            state_q <= SCAN;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign COL          = ~(4'b0001 << col_q);
    assign {D, C, B, A} = code_q;
    assign E            = e_q;

endmodule

// File: tb/tb_keypad_matrix_encoder.sv
// Randomized and directed bench for keypad_matrix_encoder.
// Keypad is modelled as a pressed[row][col] array shorting rows to driven columns.
module tb_keypad_matrix_encoder;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic       CLK;
    logic       RESET;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic       A, B, C, D, E;

    logic [3:0][3:0] pressed;

    int errs;
    int checks;

    // Reference model state (key-level view of the scanner).
    int m_cyc;
    int m_ticks;
    int m_col;
    int m_ph;
    int m_cnt;
    int m_row;
    int m_ccol;
    logic [3:0] m_code;
    logic       m_e;

    keypad_matrix_encoder #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .ROW  (ROW),
        .COL  (COL),
        .A    (A),
        .B    (B),
        .C    (C),
        .D    (D),
        .E    (E)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A pressed key pulls its row low while its column is driven.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !COL[c]) ROW[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One scan tick of the reference model, from the keys actually pressed.
    task automatic model_tick();
        int hit;
        m_ticks++;
        case (m_ph)
            0: begin
                hit = -1;
                for (int r = 3; r >= 0; r--)
                    if (pressed[r][m_col]) hit = r;
                if (hit >= 0) begin
                    m_row  = hit;
                    m_ccol = m_col;
                    m_cnt  = 0;
                    m_ph   = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
            1: begin
                if (pressed[m_row][m_ccol]) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_code = 4'(4 * m_row + m_ccol);
                        m_e    = 1'b1;
                        m_ph   = 2;
                    end
                end else begin
                    m_col = (m_col + 1) % 4;
                    m_ph  = 0;
                end
            end
            2: begin
                if (!pressed[m_row][m_ccol]) begin
                    m_cnt = 0;
                    m_ph  = 3;
                end
            end
            default: begin
                if (!pressed[m_row][m_ccol]) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_e   = 1'b0;
                        m_col = (m_col + 1) % 4;
                        m_ph  = 0;
                    end
                end else begin
                    m_ph = 2;
                end
            end
        endcase
    endtask

    task automatic model_edge();
        if (RESET) begin
            m_cyc  = 0;
            m_col  = 0;
            m_ph   = 0;
            m_cnt  = 0;
            m_code = 4'h0;
            m_e    = 1'b0;
        end else if (m_cyc != SD - 1) begin
            m_cyc++;
        end else begin
            m_cyc = 0;
            model_tick();
        end
    endtask

    // Advance one clock and compare all outputs on the falling edge.
    task automatic step();
        logic [3:0] exp_col;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        exp_col = 4'(~(4'b0001 << m_col));
        chk("col", COL, exp_col);
        chk("code", {D, C, B, A}, m_code);
        chk("e", {3'b000, E}, {3'b000, m_e});
    endtask

    task automatic run_ticks(input int n);
        int t0;
        int guard;
        t0 = m_ticks;
        guard = 0;
        while (m_ticks < t0 + n && guard < n * SD + 8) begin
            step();
            guard++;
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        repeat (n) step();
        RESET = 1'b0;
    endtask

    initial begin
        int guard;
        errs    = 0;
        checks  = 0;
        pressed = '0;
        RESET   = 1'b1;

        // 1: reset with a key held, then free scan.
        pressed[1][2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_col", COL, 4'b1110);
            chk("rst_e", {3'b000, E}, 4'h0);
            chk("rst_code", {D, C, B, A}, 4'h0);
        end
        RESET   = 1'b0;
        pressed = '0;
        repeat (3) step();
        chk("pre_tick_col", COL, 4'b1110);
        step();
        chk("tick1_col", COL, 4'b1101);
        run_ticks(1);
        chk("tick2_col", COL, 4'b1011);
        run_ticks(1);
        chk("tick3_col", COL, 4'b0111);
        run_ticks(1);
        chk("wrap_col", COL, 4'b1110);

        // 2: clean press of (2,1).
        pressed[2][1] = 1'b1;
        run_ticks(10);
        chk("p2_e", {3'b000, E}, 4'h1);
        chk("p2_code", {D, C, B, A}, 4'h9);
        chk("p2_col", COL, 4'b1101);
        pressed = '0;
        run_ticks(5);
        chk("p2_rel_e", {3'b000, E}, 4'h0);
        chk("p2_keep", {D, C, B, A}, 4'h9);

        // 3: bouncy press of (0,3), then a clean one.
        pressed[0][3] = 1'b1;
        guard = 0;
        while (m_ph != 1 && guard < 10) begin
            run_ticks(1);
            guard++;
        end
        run_ticks(1);
        pressed = '0;
        run_ticks(1);
        chk("p3_e", {3'b000, E}, 4'h0);
        chk("p3_col", COL, 4'b1110);
        pressed[0][3] = 1'b1;
        run_ticks(10);
        chk("p3b_e", {3'b000, E}, 4'h1);
        chk("p3b_code", {D, C, B, A}, 4'h3);
        pressed = '0;
        run_ticks(5);

        // 4: release bounce on (3,3).
        pressed[3][3] = 1'b1;
        run_ticks(10);
        chk("p4_code", {D, C, B, A}, 4'hF);
        pressed = '0;
        run_ticks(1);
        pressed[3][3] = 1'b1;
        run_ticks(1);
        pressed = '0;
        run_ticks(1);
        chk("p4_bounce_e", {3'b000, E}, 4'h1);
        run_ticks(2);
        chk("p4_late_e", {3'b000, E}, 4'h1);
        run_ticks(1);
        chk("p4_fall_e", {3'b000, E}, 4'h0);
        chk("p4_keep", {D, C, B, A}, 4'hF);

        // 5: two keys in one column, then a third during hold.
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        run_ticks(10);
        chk("p5_code", {D, C, B, A}, 4'h4);
        pressed[2][2] = 1'b1;
        run_ticks(6);
        chk("p5_hold_e", {3'b000, E}, 4'h1);
        chk("p5_hold_code", {D, C, B, A}, 4'h4);
        chk("p5_hold_col", COL, 4'b1110);
        pressed = '0;
        run_ticks(5);

        // 6: reset during hold, key re-detected afterwards.
        pressed[0][1] = 1'b1;
        run_ticks(10);
        chk("p6_e", {3'b000, E}, 4'h1);
        do_reset(1);
        chk("p6_rst_e", {3'b000, E}, 4'h0);
        chk("p6_rst_code", {D, C, B, A}, 4'h0);
        chk("p6_rst_col", COL, 4'b1110);
        run_ticks(10);
        chk("p6_re_e", {3'b000, E}, 4'h1);
        chk("p6_re_code", {D, C, B, A}, 4'h1);
        pressed = '0;
        run_ticks(5);

        // Random key patterns, hold times and occasional resets.
        for (int ep = 0; ep < 80; ep++) begin
            pressed = '0;
            for (int k = $urandom_range(0, 2); k > 0; k--)
                pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 2));
            run_ticks($urandom_range(1, 9));
        end
        pressed = '0;
        run_ticks(8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_encoder.md
Name: keypad_matrix_encoder

Overview:
- Drives a 4x4 matrix keypad and produces the 4-bit key code {D,C,B,A} plus the data-available strobe E consumed by the keyboard input module.
- Sits between the physical keypad pins and the keyboard/decoder path, and replaces an external 74C922-style encoder.
- Scans the columns, debounces presses and releases, holds the code latched, and raises E while a debounced key is held.

Parameters:
- SCAN_DIV, 10000, CLK cycles per scan tick (1 ms at 10 MHz); must be ≥ 4.
- DEBOUNCE_TICKS, 4, consecutive ticks needed to accept a press or a release; must be ≥ 1.

Ports:
- CLK  input  1  system clock, 10 MHz.
- RESET  input  1  synchronous, active-high reset.
- ROW  input  4  keypad row lines, active-low, pulled up externally, asynchronous.
- COL  output  4  keypad column drive, active-low, exactly one bit low at all times.
- A  output  1  key code bit 0.
- B  output  1  key code bit 1.
- C  output  1  key code bit 2.
- D  output  1  key code bit 3.
- E  output  1  data available: high while the debounced key is held.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- Reset values:
  - COL = 4'b1110 (column 0 driven).
  - {D,C,B,A} = 0, E = 0.
  - State = SCAN; tick, debounce and column counters = 0; synchronizer flops = 4'b1111.
  - RESET asserted mid-press or mid-hold aborts immediately to these values. E falls in the cycle after RESET is sampled.
- ROW passes through a 2-flop synchronizer before any use.
- Tick: a single-cycle pulse every SCAN_DIV cycles, from a free-running counter. All scan and debounce decisions are made only on tick cycles, so each column settles for SCAN_DIV-1 cycles before sampling.
- Code encoding: code = 4*row_idx + col_idx, giving {D,C,B,A}. Key mapping to symbols belongs to the downstream decoder.
- Multiple rows low in the active column: the lowest row index wins.
- States:
  - SCAN: on each tick, if any synced ROW bit is low, latch cand_row/cand_col, keep the column, set deb_cnt = 0, and go to PRESS_DEB. Otherwise advance the column 0→1→2→3→0 (COL rotates left, wraps).
  - PRESS_DEB: on each tick, if ROW[cand_row] is low, deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, register the code onto {D,C,B,A}, set E = 1 in the same edge, and go to HOLD. If ROW[cand_row] is high, advance the column and go to SCAN; E stays 0 and the code is unchanged.
  - HOLD: the column is frozen and other keys are ignored. On the first tick with ROW[cand_row] high, set deb_cnt = 0 and go to REL_DEB.
  - REL_DEB: on each tick, if ROW[cand_row] is high, deb_cnt++. When it reaches DEBOUNCE_TICKS, set E = 0, advance the column, and go to SCAN. If ROW[cand_row] is low again, return to HOLD with E still 1.
- Press latency: E rises at the clock edge of the DEBOUNCE_TICKS-th tick after the detecting tick.
- Release latency: E falls at the DEBOUNCE_TICKS-th tick after the first release tick (the tick where HOLD sees the row high).
- {D,C,B,A} keep the last accepted code after E falls, and change only when E rises.
- E high never overlaps a code change, so the downstream pulse generator sees a stable code on its rising edge.

Decomposition:
- Shared package keypad_pkg:
  - State encoding constants SCAN, PRESS_DEB, HOLD, REL_DEB.
  - NUM_ROWS = 4, NUM_COLS = 4, CODE_W = 4.
  - COL_RESET = 4'b1110.
- Sub-module keypad_tick_gen (parameter SCAN_DIV): counter with synchronous reset that outputs a 1-cycle tick. Everything else (synchronizer, FSM, code register) stays in keypad_matrix_encoder.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3. The bench keypad model drives ROW[r] = 0 iff COL[c] = 0 and key (r,c) is pressed.
1. Reset: assert RESET 3 cycles with key (1,2) held → COL=4'b1110, E=0, {D,C,B,A}=0 throughout reset; COL steps 1110→1101→1011→0111→1110 every 4 cycles after release.
2. Clean press of key (2,1) for 40 cycles → E rises exactly 3 ticks after the detecting tick with {D,C,B,A}=4'h9; COL frozen at 4'b1101 while E=1.
3. Bouncy press of key (0,3), high on the 2nd debounce tick → no E; scan resumes at column 0; a later clean press yields E=1 with code 4'h3.
4. Release bounce: key (3,3) accepted (code 4'hF), then released 1 tick, pressed 1 tick, then released → E stays 1 through the bounce and falls 3 ticks after final release; code stays 4'hF.
5. Two keys (1,0) and (3,0) pressed together → code 4'h4 (lowest row wins); pressing key (2,2) during HOLD is ignored.
6. RESET mid-HOLD with E=1 → E=0, code=0, COL=4'b1110 on the next edge; the held key is re-detected and re-debounced after RESET deasserts.
